// File: rtl/sw_write_ctrl.sv
// Write-side driver for the lab2 data register: synchronizes and debounces a push-button,
// then issues one write strobe per press together with a held switch snapshot.
module sw_write_ctrl #(
  parameter int unsigned DATA_WIDTH      = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  btn_i,
  input  logic [DATA_WIDTH-1:0] sw_i,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [CNT_WIDTH-1:0]  wr_cnt_o,
  output logic                  busy_o
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    PRESSED
  } state_t;

  logic [SYNC_STAGES-1:0] btn_sync;
  logic [DATA_WIDTH-1:0]  sw_sync [SYNC_STAGES];
  logic                   btn_s;
  logic [DATA_WIDTH-1:0]  sw_s;

  logic [DB_W-1:0]        db_cnt;
  logic                   btn_db;

  state_t                 state, state_d;
  logic                   wr_en_d;
  logic [DATA_WIDTH-1:0]  wr_data_d;
  logic [CNT_WIDTH-1:0]   wr_cnt_d;
  logic                   busy_d;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      btn_sync <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
    end else begin
      btn_sync   <= {btn_sync[SYNC_STAGES-2:0], btn_i};
      sw_sync[0] <= sw_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
    end
  end

  assign btn_s = btn_sync[SYNC_STAGES-1];
  assign sw_s  = sw_sync[SYNC_STAGES-1];

  // Level is accepted on the edge where the count already sits at DB_MAX,
  // so a change needs DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_s != btn_db) begin
      if (db_cnt == DB_MAX) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state     <= IDLE;
      wr_en_o   <= 1'b0;
      wr_data_o <= '0;
      wr_cnt_o  <= '0;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_d;
      wr_en_o   <= wr_en_d;
      wr_data_o <= wr_data_d;
      wr_cnt_o  <= wr_cnt_d;
      busy_o    <= busy_d;
    end
  end

  // btn_db is always low on entry to IDLE, so a high level there is the rising edge.
  always_comb begin
    state_d   = state;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_o;
    wr_cnt_d  = wr_cnt_o;
    busy_d    = busy_o;
    case (state)
      IDLE: begin
        if (btn_db) begin
          state_d   = PRESSED;
          wr_en_d   = 1'b1;
          wr_data_d = sw_s;
          wr_cnt_d  = wr_cnt_o + 1'b1;
          busy_d    = 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_db) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sw_write_ctrl.sv
// Directed bench for sw_write_ctrl with SYNC_STAGES=2, DEBOUNCE_CYCLES=4: strobe latency,
// bounce rejection, data hold, counter wrap and asynchronous reset cases.
module tb_sw_write_ctrl;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         arst_i;
  logic         btn_i;
  logic [W-1:0] sw_i;
  logic         wr_en_o;
  logic [W-1:0] wr_data_o;
  logic [7:0]   wr_cnt_o;
  logic         busy_o;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic width_err = 1'b0;
  logic prev_en   = 1'b0;

  sw_write_ctrl #(
    .DATA_WIDTH     (W),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (8)
  ) dut (
    .clk_i    (clk),
    .arst_i   (arst_i),
    .btn_i    (btn_i),
    .sw_i     (sw_i),
    .wr_en_o  (wr_en_o),
    .wr_data_o(wr_data_o),
    .wr_cnt_o (wr_cnt_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en_o) begin
      pulses = pulses + 1;
      if (prev_en) width_err = 1'b1;
    end
    prev_en = wr_en_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Returns the index of the first edge showing wr_en_o high, 0 on timeout.
  task automatic edges_to_strobe(input int budget, output int e);
    e = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (wr_en_o) begin
        e = i;
        break;
      end
    end
  endtask

  // Clean release: btn_s falls at edge 2, btn_db at edge 6, busy_o at edge 7.
  task automatic release_check(input string tag);
    btn_i = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check(tag, busy_o, (e < 7) ? 32'd1 : 32'd0);
    end
  endtask

  int e;
  int p0;
  logic [7:0] exp_cnt;
  logic saw_wrap;

  initial begin
    arst_i = 1'b0;
    btn_i  = 1'b1;
    sw_i   = 10'h3FF;

    // 1: reset state, then latency with button held through release
    ticks(3);
    check("rst_en",   wr_en_o,   0);
    check("rst_data", wr_data_o, 0);
    check("rst_cnt",  wr_cnt_o,  0);
    check("rst_busy", busy_o,    0);
    #4 arst_i = 1'b1;
    edges_to_strobe(20, e);
    check("t1_edge", e, 7);
    check("t1_data", wr_data_o, 10'h3FF);
    check("t1_cnt",  wr_cnt_o, 1);
    check("t1_busy", busy_o, 1);
    tick();
    check("t1_width", wr_en_o, 0);
    ticks(10);
    check("t1_hold_one", pulses, 1);
    release_check("t1_busy_rel");

    // 2: clean press
    p0 = pulses;
    sw_i  = 10'h155;
    btn_i = 1'b1;
    ticks(20);
    check("t2_pulses", pulses - p0, 1);
    check("t2_data", wr_data_o, 10'h155);
    check("t2_cnt",  wr_cnt_o, 2);
    release_check("t2_busy_rel");

    // 3: bouncing press then bouncing release
    p0 = pulses;
    btn_i = 1'b1; ticks(1); btn_i = 1'b0; ticks(1);
    btn_i = 1'b1; ticks(2); btn_i = 1'b0; ticks(1);
    btn_i = 1'b1; ticks(3); btn_i = 1'b0; ticks(1);
    check("t3_no_early", pulses - p0, 0);
    btn_i = 1'b1;
    edges_to_strobe(20, e);
    check("t3_edge", e, 7);
    check("t3_cnt",  wr_cnt_o, 3);
    btn_i = 1'b0; ticks(1); btn_i = 1'b1; ticks(1);
    btn_i = 1'b0; ticks(2); btn_i = 1'b1; ticks(2);
    check("t3_busy_bounce", busy_o, 1);
    btn_i = 1'b0;
    ticks(12);
    check("t3_busy_rel", busy_o, 0);
    check("t3_pulses", pulses - p0, 1);

    // 4: data hold while busy and in idle
    sw_i  = 10'h0AA;
    btn_i = 1'b1;
    edges_to_strobe(20, e);
    check("t4_edge", e, 7);
    check("t4_data", wr_data_o, 10'h0AA);
    sw_i = 10'h3C3;
    ticks(5);
    check("t4_busy", busy_o, 1);
    check("t4_hold_busy", wr_data_o, 10'h0AA);
    btn_i = 1'b0;
    ticks(10);
    check("t4_idle", busy_o, 0);
    check("t4_hold_idle", wr_data_o, 10'h0AA);
    btn_i = 1'b1;
    edges_to_strobe(20, e);
    check("t4_data2", wr_data_o, 10'h3C3);
    check("t4_cnt", wr_cnt_o, 5);
    btn_i = 1'b0;
    ticks(10);

    // 5: 256 presses wrap the counter back to its start value
    p0 = pulses;
    exp_cnt = 8'd5;
    saw_wrap = 1'b0;
    for (int i = 0; i < 256; i++) begin
      btn_i = 1'b1;
      ticks(10);
      exp_cnt = exp_cnt + 8'd1;
      check("t5_cnt", wr_cnt_o, exp_cnt);
      if (exp_cnt == 8'd0 && wr_cnt_o == 8'd0) saw_wrap = 1'b1;
      btn_i = 1'b0;
      ticks(10);
    end
    check("t5_pulses", pulses - p0, 256);
    check("t5_wrap", saw_wrap, 1);
    check("t5_final", wr_cnt_o, 5);

    // 6a: reset during the strobe cycle, button kept held
    btn_i = 1'b1;
    edges_to_strobe(20, e);
    check("t6_edge", e, 7);
    #3 arst_i = 1'b0;
    #1;
    check("t6_en_async", wr_en_o, 0);
    check("t6_cnt_async", wr_cnt_o, 0);
    check("t6_busy_async", busy_o, 0);
    check("t6_data_async", wr_data_o, 0);
    ticks(3);
    #4 arst_i = 1'b1;
    edges_to_strobe(20, e);
    check("t6_redo_edge", e, 7);
    check("t6_redo_cnt", wr_cnt_o, 1);
    btn_i = 1'b0;
    ticks(10);

    // 6b: reset at debounce count 2 discards the press; debounce restarts after release
    p0 = pulses;
    btn_i = 1'b1;
    ticks(4);
    arst_i = 1'b0;
    ticks(2);
    check("t6_mid_none", pulses - p0, 0);
    check("t6_mid_busy", busy_o, 0);
    #4 arst_i = 1'b1;
    edges_to_strobe(20, e);
    check("t6_mid_edge", e, 7);
    check("t6_mid_cnt", wr_cnt_o, 1);
    btn_i = 1'b0;
    ticks(10);
    check("t6_mid_pulses", pulses - p0, 1);

    check("pulse_width", width_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
